adder_arb_seq: RTL

Sequencer and arbiter that shares one registered-input 8-bit adder core between two requesters. It performs multi-precision additions of WORDS×WIDTH bits by issuing one WIDTH-bit slice at a time, LSB slice first. Each slice's carry-out is chained into the next slice's carry-in. It sits between the requesting datapaths and the single adder instance, and returns a full-width sum and carry-out per transaction.

---
 rtl/adder_arb_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/adder_arb_seq.sv
// -----------------------------------------------------------------------------
// adder_arb_seq
//
// Shares one registered-input WIDTH-bit adder core between two requesters and
// performs WORDS x WIDTH-bit additions by issuing one slice at a time, LSB
// slice first. Each slice's carry-out feeds the next slice's carry-in.
//
// Parameters
//   WIDTH    slice width; must match the adder core
//   WORDS    slices per transaction (1..16)
//   ADD_LAT  core latency, add_valid to add_ready; sizes the stall watchdog
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     requester N handshake (N = 0, 1)
//   reqN_x, reqN_y, reqN_cin    requester N operands
//   add_valid, add_x, add_y,
//   add_cin                     slice issue to the adder core
//   add_z, add_cout, add_ready  slice result from the adder core
//   rsp_valid / rsp_ready       result handshake
//   rsp_id, rsp_sum, rsp_cout   result owner, full sum, final carry
//   rsp_ovf                     signed overflow (only with ADDSEQ_OVERFLOW_EN)
//   busy                        FSM is not in IDLE
//   stall_err                   sticky: core did not answer within 4*ADD_LAT
//
// Build option
//   ADDSEQ_OVERFLOW_EN  adds rsp_ovf, the two's-complement overflow of the
//                       full-width add.
// -----------------------------------------------------------------------------
module adder_arb_seq #(
  parameter int WIDTH   = 8,
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH*WORDS-1:0] req0_x,
  input  logic [WIDTH*WORDS-1:0] req0_y,
  input  logic                   req0_cin,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH*WORDS-1:0] req1_x,
  input  logic [WIDTH*WORDS-1:0] req1_y,
  input  logic                   req1_cin,

  output logic                   add_valid,
  output logic [WIDTH-1:0]       add_x,
  output logic [WIDTH-1:0]       add_y,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_z,
  input  logic                   add_cout,
  input  logic                   add_ready,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH*WORDS-1:0] rsp_sum,
  output logic                   rsp_cout,
`ifdef ADDSEQ_OVERFLOW_EN
  output logic                   rsp_ovf,
`endif
  output logic                   busy,
  output logic                   stall_err
);

  localparam int N        = WIDTH * WORDS;
  localparam int IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WD_LIMIT = 4 * ADD_LAT;
  localparam int WDW      = $clog2(WD_LIMIT + 1);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(WD_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic            ptr;      // requester that wins when both ask
  logic [IDXW-1:0] idx;      // slice currently in flight
  logic [WDW-1:0]  wd_cnt;   // WAIT cycles spent on the current slice
  logic [N-1:0]    x_reg;
  logic [N-1:0]    y_reg;

  // Arbitration and next-slice selection
  logic            both;
  logic            gnt_any;
  logic            gnt_id;
  logic [N-1:0]    gnt_x;
  logic [N-1:0]    gnt_y;
  logic            gnt_cin;
  logic [IDXW-1:0] idx_next;
  int              cur_base;
  int              nxt_base;

  always_comb begin
    both     = req0_valid & req1_valid;
    gnt_any  = req0_valid | req1_valid;
    gnt_id   = both ? ptr : req1_valid;
    gnt_x    = gnt_id ? req1_x   : req0_x;
    gnt_y    = gnt_id ? req1_y   : req0_y;
    gnt_cin  = gnt_id ? req1_cin : req0_cin;
    idx_next = idx + IDXW'(1);
    cur_base = int'(idx) * WIDTH;
    nxt_base = int'(idx_next) * WIDTH;
  end

  // Single FSM; every output is a register updated on state transitions so
  // that the strobes line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      idx        <= '0;
      wd_cnt     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      add_valid  <= 1'b0;
      add_x      <= '0;
      add_y      <= '0;
      add_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
`ifdef ADDSEQ_OVERFLOW_EN
      rsp_ovf    <= 1'b0;
`endif
      busy       <= 1'b0;
      stall_err  <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_any) begin
            req0_ready <= ~gnt_id;
            req1_ready <= gnt_id;
            // A lone request leaves the round-robin pointer untouched.
            if (both) begin
              ptr <= ~gnt_id;
            end
            x_reg     <= gnt_x;
            y_reg     <= gnt_y;
            // Slice 0 is presented straight from the request so ISSUE can
            // strobe the core on the very next cycle.
            add_x     <= gnt_x[WIDTH-1:0];
            add_y     <= gnt_y[WIDTH-1:0];
            add_cin   <= gnt_cin;
            add_valid <= 1'b1;
            idx       <= '0;
            wd_cnt    <= '0;
            rsp_id    <= gnt_id;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDSEQ_OVERFLOW_EN
            rsp_ovf   <= 1'b0;
`endif
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          add_valid <= 1'b0;
          wd_cnt    <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (add_ready) begin
            rsp_sum[cur_base +: WIDTH] <= add_z;
            if (idx == LAST_IDX) begin
              rsp_cout  <= add_cout;
`ifdef ADDSEQ_OVERFLOW_EN
              // carry into MSB = z ^ x ^ y at the MSB; overflow = that ^ cout
              rsp_ovf   <= add_z[WIDTH-1] ^ x_reg[N-1] ^ y_reg[N-1] ^ add_cout;
`else
              // signed overflow is not tracked in this build
`endif
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // add_cin doubles as the stored chained carry.
              idx       <= idx_next;
              add_x     <= x_reg[nxt_base +: WIDTH];
              add_y     <= y_reg[nxt_base +: WIDTH];
              add_cin   <= add_cout;
              add_valid <= 1'b1;
              state     <= ISSUE;
            end
          end else if (wd_cnt == WD_LAST) begin
            // Core never answered: drop the transaction without a response.
            stall_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
